// File: rtl/mips_control_muldiv_sequencer_pkg.sv
// Shared definitions for the MIPS multiply/divide sequencer: op and state
// encodings plus small decode helpers.
package mips_control_muldiv_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_ITER = 2'd2,
        ST_FIX  = 2'd3
    } muldiv_state_e;

    // Signed ops need magnitude conversion and a sign fix-up at the end.
    function automatic logic is_signed(input muldiv_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div(input muldiv_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mips_control_muldiv_sequencer_if.sv
// EX-stage <-> multiply/divide sequencer bundle.
//
// Handshake: EX raises start (with op/rs/rt) for one cycle to issue. The issue
// is accepted at the next rising edge only when busy is low; while busy is
// high, stall is raised combinationally for any start/mfhi/mflo/mthi/mtlo and
// the requester must hold and re-present the request until stall drops.
// flush aborts any in-flight op without touching HI/LO.
interface mips_control_muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             mthi;
    logic             mtlo;
    logic             mfhi;
    logic             mflo;
    logic             flush;
    logic             busy;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs, rt, mthi, mtlo, mfhi, mflo, flush,
        input  busy, stall, hi, lo
    );

    modport slave (
        input  start, op, rs, rt, mthi, mtlo, mfhi, mflo, flush,
        output busy, stall, hi, lo
    );
endinterface

// File: rtl/mips_control_muldiv_step.sv
// One radix-2 iteration of the mul/div engine. acc is the upper working word
// (partial product / partial remainder), mq the lower (multiplier / dividend
// shifting into quotient), b the operand magnitude (multiplicand / divisor).
module mips_control_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] mq_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] mq_o
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    // Multiply: conditional add then right shift of {carry, acc, mq}.
    // Divide: shift next dividend bit into the remainder, trial-subtract, and
    // shift the resulting quotient bit into mq. Extra diff bit is the borrow.
    always_comb begin
        sum     = {1'b0, acc_i} + (mq_i[0] ? {1'b0, b_i} : {(WIDTH + 1){1'b0}});
        shifted = {acc_i, mq_i[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, b_i};
        acc_o   = sum[WIDTH:1];
        mq_o    = {sum[0], mq_i[WIDTH-1:1]};
        if (div_i) begin
            if (diff[WIDTH+1]) begin
                acc_o = shifted[WIDTH-1:0];
                mq_o  = {mq_i[WIDTH-2:0], 1'b0};
            end else begin
                acc_o = diff[WIDTH-1:0];
                mq_o  = {mq_i[WIDTH-2:0], 1'b1};
            end
        end
    end
endmodule

// File: rtl/mips_control_muldiv_sequencer.sv
// Iterative multiply/divide controller and HI/LO owner sitting beside EX.
// Fixed latency: start seen at edge 0, HI/LO valid after edge WIDTH+2.
module mips_control_muldiv_sequencer
    import mips_control_muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                            clock,
    input  logic                            reset_n,
    mips_control_muldiv_sequencer_if.slave  bus,
    output muldiv_state_e                   dbg_state
);
    muldiv_state_e    state_q;
    logic [CNT_W-1:0] cnt_q;
    muldiv_op_e       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mq_q;
    logic             neg_lo_q;
    logic             neg_hi_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic               busy;
    logic               sgn;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   step_acc;
    logic [WIDTH-1:0]   step_mq;

    mips_control_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_i (is_div(op_q)),
        .acc_i (acc_q),
        .mq_i  (mq_q),
        .b_i   (b_q),
        .acc_o (step_acc),
        .mq_o  (step_mq)
    );

    // Operand magnitudes for PREP and sign-corrected results for FIX.
    always_comb begin
        sgn      = is_signed(op_q);
        a_neg    = sgn & a_q[WIDTH-1];
        b_neg    = sgn & b_q[WIDTH-1];
        a_mag    = a_neg ? ({WIDTH{1'b0}} - a_q) : a_q;
        b_mag    = b_neg ? ({WIDTH{1'b0}} - b_q) : b_q;
        prod_fix = neg_lo_q ? ({(2*WIDTH){1'b0}} - {acc_q, mq_q}) : {acc_q, mq_q};
        quo_fix  = neg_lo_q ? ({WIDTH{1'b0}} - mq_q) : mq_q;
        rem_fix  = neg_hi_q ? ({WIDTH{1'b0}} - acc_q) : acc_q;
    end

    // FSM, iteration counter, working registers and the architectural HI/LO.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MULT;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        // A squashed issue is simply not taken; MT writes
                        // paired with a start are dropped either way.
                        if (!bus.flush) begin
                            state_q <= ST_PREP;
                            op_q    <= muldiv_op_e'(bus.op);
                            a_q     <= bus.rs;
                            b_q     <= bus.rt;
                        end
                    end else begin
                        if (bus.mthi) hi_q <= bus.rs;
                        if (bus.mtlo) lo_q <= bus.rs;
                    end
                end
                ST_PREP: begin
                    if (bus.flush) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q  <= ST_ITER;
                        cnt_q    <= CNT_W'(WIDTH - 1);
                        acc_q    <= '0;
                        mq_q     <= a_mag;
                        b_q      <= b_mag;
                        neg_lo_q <= a_neg ^ b_neg;
                        neg_hi_q <= a_neg;
                    end
                end
                ST_ITER: begin
                    if (bus.flush) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        acc_q <= step_acc;
                        mq_q  <= step_mq;
                        if (cnt_q == '0) begin
                            state_q <= ST_FIX;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                ST_FIX: begin
                    state_q <= ST_IDLE;
                    if (!bus.flush) begin
                        if (is_div(op_q)) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Busy and stall are combinational so EX sees the hold in the same cycle.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        bus.busy  = busy;
        bus.stall = busy & (bus.start | bus.mfhi | bus.mflo | bus.mthi | bus.mtlo);
        bus.hi    = hi_q;
        bus.lo    = lo_q;
        dbg_state = state_q;
    end
endmodule

// File: tb/tb_mips_control_muldiv_sequencer.sv
// Self-checking bench for the multiply/divide sequencer.
module tb_mips_control_muldiv_sequencer;
    import mips_control_muldiv_sequencer_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic clock;
    logic reset_n;
    muldiv_state_e dbg_state;

    mips_control_muldiv_sequencer_if #(.WIDTH(W)) bus ();

    mips_control_muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int checks   = 0;
    int failures = 0;
    logic [2*W-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model: returns {hi, lo} ----------------
    function automatic logic [2*W-1:0] model(input logic [1:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [2*W-1:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: res = sa * sb;
            2'd1: res = {32'b0, a} * {32'b0, b};
            2'd2: begin
                if (b == '0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == '0) res = {a, 32'hFFFF_FFFF};
                else         res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs    = a;
        bus.rt    = b;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic write_hilo(input logic [W-1:0] h, input logic [W-1:0] l);
        bus.mthi = 1'b1;
        bus.rs   = h;
        @(negedge clock);
        bus.mthi = 1'b0;
        bus.mtlo = 1'b1;
        bus.rs   = l;
        @(negedge clock);
        bus.mtlo = 1'b0;
    endtask

    // Issue one op, count busy cycles, compare result against the scoreboard.
    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        logic [2*W-1:0] exp;
        exp_q.push_back(model(op, a, b));
        issue(op, a, b);
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clock);
        end
        checks++;
        if (n != LAT) begin
            failures++;
            $display("FAIL %s_latency busy_cycles=%0d expected=%0d", name, n, LAT);
        end
        exp = exp_q.pop_front();
        checks++;
        if ({bus.hi, bus.lo} !== exp) begin
            failures++;
            $display("FAIL %s_result hi_lo=%h expected=%h", name, {bus.hi, bus.lo}, exp);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.hi !== '0 || bus.lo !== '0
            || dbg_state !== ST_IDLE) begin
            failures++;
            $display("FAIL reset busy=%b stall=%b hi=%h lo=%h state=%0d expected all zero",
                     bus.busy, bus.stall, bus.hi, bus.lo, dbg_state);
        end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_mthi_mtlo();
        write_hilo(32'hDEAD_BEEF, 32'h0BAD_F00D);
        checks++;
        if (bus.hi !== 32'hDEAD_BEEF || bus.lo !== 32'h0BAD_F00D) begin
            failures++;
            $display("FAIL mthi_mtlo hi=%h lo=%h expected=deadbeef 0badf00d", bus.hi, bus.lo);
        end
        // mfhi in IDLE never stalls
        bus.mfhi = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL mfhi_idle_stall stall=%b expected=0", bus.stall);
        end
        bus.mfhi = 1'b0;
        // start together with mthi: start wins, HI not overwritten by rs
        bus.mthi = 1'b1;
        exp_q.push_back(model(2'd1, 32'd5, 32'd3));
        issue(2'd1, 32'd5, 32'd3);
        bus.mthi = 1'b0;
        checks++;
        if (bus.hi !== 32'hDEAD_BEEF || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL start_wins hi=%h busy=%b expected=deadbeef 1", bus.hi, bus.busy);
        end
        repeat (LAT) @(negedge clock);
        begin
            logic [2*W-1:0] exp;
            exp = exp_q.pop_front();
            checks++;
            if ({bus.hi, bus.lo} !== exp) begin
                failures++;
                $display("FAIL start_wins_result hi_lo=%h expected=%h", {bus.hi, bus.lo}, exp);
            end
        end
    endtask

    task automatic test_mul();
        run_op("multu_ffff_2", 2'd1, 32'hFFFF_FFFF, 32'd2);
        run_op("mult_m1_2",    2'd0, 32'hFFFF_FFFF, 32'd2);
        run_op("mult_neg_neg", 2'd0, 32'h8000_0000, 32'h8000_0000);
        run_op("multu_zero",   2'd1, 32'h1234_5678, 32'd0);
    endtask

    task automatic test_div();
        run_op("div_m7_2",      2'd2, 32'hFFFF_FFF9, 32'd2);
        run_op("div_min_m1",    2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_by_zero",  2'd3, 32'h0000_1234, 32'd0);
        run_op("div_by_zero",   2'd2, 32'h0000_0777, 32'd0);
        run_op("div_7_m2",      2'd2, 32'd7, 32'hFFFF_FFFE);
        run_op("divu_big",      2'd3, 32'hFFFF_FFFF, 32'h0001_0001);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            logic [1:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom >> $urandom_range(0, 28);
            if (op[1] && b == '0) b = 32'd1;
            run_op("random", op, a, b);
        end
    endtask

    // Issue MULTU, hold mflo from cycle 3 on and re-present a start mid-op.
    task automatic test_stall_mflo();
        logic [2*W-1:0] exp;
        logic           exp_stall;
        exp_q.push_back(model(2'd1, 32'h1234_5678, 32'h0000_0100));
        issue(2'd1, 32'h1234_5678, 32'h0000_0100);
        for (int k = 1; k <= 40; k++) begin
            bus.mflo  = (k >= 3);
            bus.start = (k >= 5 && k <= 7);
            bus.op    = 2'd3;
            bus.rs    = 32'd99;
            bus.rt    = 32'd9;
            #1;
            exp_stall = (k <= LAT) && (k >= 3);
            checks++;
            if (bus.stall !== exp_stall || bus.busy !== (k <= LAT)) begin
                failures++;
                $display("FAIL stall_cycle_%0d stall=%b busy=%b expected=%b %b",
                         k, bus.stall, bus.busy, exp_stall, (k <= LAT));
            end
            if (k == LAT + 1) begin
                exp = exp_q.pop_front();
                checks++;
                if (bus.lo !== exp[W-1:0]) begin
                    failures++;
                    $display("FAIL mflo_value lo=%h expected=%h", bus.lo, exp[W-1:0]);
                end
            end
            @(negedge clock);
        end
        bus.mflo  = 1'b0;
        bus.start = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0 || {bus.hi, bus.lo} !== exp) begin
            failures++;
            $display("FAIL second_start_dropped busy=%b hi_lo=%h expected=0 %h",
                     bus.busy, {bus.hi, bus.lo}, exp);
        end
    endtask

    task automatic test_flush();
        write_hilo(32'hAAAA_5555, 32'h0F0F_0F0F);
        issue(2'd3, 32'd1000, 32'd7);
        repeat (10) @(negedge clock);
        checks++;
        if (dbg_state !== ST_ITER) begin
            failures++;
            $display("FAIL flush_pre_state state=%0d expected=%0d", dbg_state, ST_ITER);
        end
        bus.flush = 1'b1;
        @(negedge clock);
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'hAAAA_5555 || bus.lo !== 32'h0F0F_0F0F) begin
            failures++;
            $display("FAIL flush_iter busy=%b hi=%h lo=%h expected=0 aaaa5555 0f0f0f0f",
                     bus.busy, bus.hi, bus.lo);
        end
        // flush while in FIX cancels the write
        issue(2'd1, 32'd12345, 32'd678);
        repeat (LAT - 1) @(negedge clock);
        checks++;
        if (dbg_state !== ST_FIX) begin
            failures++;
            $display("FAIL flush_fix_state state=%0d expected=%0d", dbg_state, ST_FIX);
        end
        bus.flush = 1'b1;
        @(negedge clock);
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'hAAAA_5555 || bus.lo !== 32'h0F0F_0F0F) begin
            failures++;
            $display("FAIL flush_fix busy=%b hi=%h lo=%h expected=0 aaaa5555 0f0f0f0f",
                     bus.busy, bus.hi, bus.lo);
        end
        // flush with start in IDLE: not taken
        bus.flush = 1'b1;
        issue(2'd0, 32'd3, 32'd3);
        bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_start_idle busy=%b expected=0", bus.busy);
        end
        run_op("after_flush", 2'd3, 32'd1000, 32'd7);
    endtask

    task automatic test_async_reset();
        issue(2'd0, 32'hFFFF_0000, 32'h0000_7777);
        repeat (9) @(negedge clock);
        bus.mfhi = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b1 || dbg_state !== ST_ITER) begin
            failures++;
            $display("FAIL pre_reset stall=%b state=%0d expected=1 %0d", bus.stall, dbg_state, ST_ITER);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.hi !== '0 || bus.lo !== '0) begin
            failures++;
            $display("FAIL async_reset busy=%b stall=%b hi=%h lo=%h expected all zero",
                     bus.busy, bus.stall, bus.hi, bus.lo);
        end
        bus.mfhi = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run_op("after_reset", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.rs    = '0;
        bus.rt    = '0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.mfhi  = 1'b0;
        bus.mflo  = 1'b0;
        bus.flush = 1'b0;
        reset_n   = 1'b0;
        @(negedge clock);
        test_reset();
        test_mthi_mtlo();
        test_mul();
        test_div();
        test_random();
        test_stall_mflo();
        test_flush();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover entries=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout time=%0t expected=finish", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mips_control_muldiv_sequencer.md
Name: mips_control_muldiv_sequencer

Overview:
- Iterative multiply/divide controller and HI/LO owner for the pipelined MIPS core. Sits beside the EX stage.
- Accepts MULT/MULTU/DIV/DIVU issues and sequences a radix-2 shift-add/restoring-subtract engine.
- Services MTHI/MTLO writes, and stalls the pipeline when an issue, MFHI/MFLO or MTHI/MTLO arrives while the engine is busy.

Parameters:
- WIDTH, 32, operand/HI/LO width (must be ≥4, even)
- CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  EX issues a mul/div op this cycle
- op  input  2  0=MULT 1=MULTU 2=DIV 3=DIVU
- rs  input  WIDTH  operand A / dividend
- rt  input  WIDTH  operand B / divisor
- mthi  input  1  write rs to HI
- mtlo  input  1  write rs to LO
- mfhi  input  1  EX reads HI this cycle
- mflo  input  1  EX reads LO this cycle
- flush  input  1  abort in-flight op (branch/exception squash)
- busy  output  1  engine not IDLE
- stall  output  1  hold EX and earlier stages
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, counter=0, hi=0, lo=0, busy=0, stall=0. Reset mid-operation discards the op.
- States:
  - IDLE: start → PREP, latching op/rs/rt.
  - PREP: 1 cycle. Signed ops take absolute values and record result signs. Loads accumulators → ITER.
  - ITER: exactly WIDTH cycles (counter WIDTH-1 down to 0) → FIX.
  - FIX: 1 cycle. Applies sign correction and writes hi/lo at its closing edge → IDLE.
- Latency: start sampled at edge 0; hi/lo hold the result after edge WIDTH+2. This is fixed for all ops and operands, including divide by zero.
- busy = (state != IDLE), combinational from state.
- stall = busy & (start | mfhi | mflo | mthi | mtlo), combinational. A start while busy is ignored (not latched); the issuing stage re-presents it.
- Multiply: 2·WIDTH-bit product; hi = upper half, lo = lower half.
  - MULT: product negated in FIX when sign(rs)^sign(rt).
- Divide: lo = quotient, hi = remainder.
  - DIV: quotient negated if sign(rs)^sign(rt); remainder takes sign of rs.
  - Most-negative / −1: lo=0x80000000, hi=0 (natural abs-arithmetic result, no trap).
  - Divide by zero, both DIV and DIVU: lo = all ones, hi = rs (unsigned magnitude result, then DIV sign fix). The raw restoring algorithm yields this; no special case is needed.
- MTHI/MTLO in IDLE: hi/lo updated at the next edge. When start and mthi/mtlo are both asserted in IDLE, start wins and the write is dropped (the single-issue pipeline never does this).
- flush: in any non-IDLE state, returns to IDLE at the next edge and hi/lo are unchanged. flush with start in IDLE means start is ignored. flush during FIX cancels the write.
- hi/lo change only at the FIX edge or on MTHI/MTLO. No partial results are visible during ITER.
- mfhi/mflo in IDLE read hi/lo directly, with no stall.

Decomposition:
- Shared package:
  - op encodings (MULT/MULTU/DIV/DIVU)
  - state encoding (IDLE/PREP/ITER/FIX)
  - helpers is_signed(op) and is_div(op)
- Sub-module mips_control_muldiv_step: combinational single iteration.
  - Multiply: conditional add plus right shift.
  - Divide: trial subtract plus left shift, quotient bit out.
- The sequencer instantiates it once and owns the FSM, counter, sign flags, stall logic and HI/LO.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=2 → after 34 cycles hi=0x00000001, lo=0xFFFFFFFE; busy high for exactly 34 cycles.
- MULT rs=0xFFFFFFFF rt=2 → hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (−7) rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU rs=0x1234 rt=0 → lo=0xFFFFFFFF, hi=0x00001234, same 34-cycle latency.
- Issue MULTU, assert mflo on cycles 3–40:
  - stall high exactly while busy, low from the first IDLE cycle;
  - mflo value then equals the product;
  - a second start during busy is not latched.
- Issue DIVU, flush at ITER cycle 10 → IDLE next cycle, hi/lo keep their prior values.
- Assert reset_n low during ITER → all outputs 0 immediately, without waiting for a clock edge.
